// File: rtl/ayatsuki_core.sv
// ayatsuki_core: 2-stage RV32I-subset core; F fetches, E decodes/executes/accesses memory/writes back.
// Optional feature macro AYATSUKI_HALT_EN: ECALL/EBREAK set a sticky halt that freezes the core until reset.
module ayatsuki_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o,
    output logic        mem_w_enable_o,
    output logic        mem_r_enable_o,
    output logic        mem_enable_o,
    output logic [31:0] mem_w_addr_o,
    output logic [31:0] mem_r_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d, exec_pc_q, exec_pc_d;
    logic        squash_q, squash_d, live_q, live_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        halted, freeze, exec_ok;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu_res, mem_addr;
    logic        alt, alu_ok, taken, br_ok;
    logic        rd_we, redirect, ld, st;
    logic [31:0] rd_val, target;

    assign opcode  = inst_i[6:0];
    assign rd      = inst_i[11:7];
    assign f3      = inst_i[14:12];
    assign rs1     = inst_i[19:15];
    assign rs2     = inst_i[24:20];
    assign f7      = inst_i[31:25];
    assign alt     = (f7 == 7'b0100000);
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];
    assign imm_i   = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u   = {inst_i[31:12], 12'h000};
    assign imm_j   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt   = alu_b[4:0];
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    // live_q masks the slot right after reset release (the ROM's reset NOP) and everything during reset.
    assign exec_ok = live_q & ~squash_q & ~halted;

`ifdef AYATSUKI_HALT_EN
    logic halt_q, halt_d, halt_set;
    assign halted = halt_q;
    assign freeze = halt_q | halt_set;
    assign halt_d = halt_q | halt_set;
`else
    assign halted = 1'b0;
    assign freeze = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (opcode == OP_REG && alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = alt ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
        if (opcode == OP_REG)
            alu_ok = (f7 == 7'b0) || (alt && (f3 == 3'b000 || f3 == 3'b101));
        else if (f3 == 3'b001)
            alu_ok = (f7 == 7'b0);
        else if (f3 == 3'b101)
            alu_ok = (f7 == 7'b0) || alt;
        else
            alu_ok = 1'b1;

        br_ok = 1'b1;
        taken = 1'b0;
        case (f3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: taken = (rs1_val < rs2_val);
            3'b111: taken = (rs1_val >= rs2_val);
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_we    = 1'b0;
        rd_val   = '0;
        redirect = 1'b0;
        target   = '0;
        ld       = 1'b0;
        st       = 1'b0;
`ifdef AYATSUKI_HALT_EN
        halt_set = 1'b0;
`endif
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_val = exec_pc_q + imm_u; end
            OP_JAL: begin
                rd_we = 1'b1; rd_val = exec_pc_q + 32'd4;
                redirect = 1'b1; target = exec_pc_q + imm_j;
            end
            OP_JALR: if (f3 == 3'b000) begin
                rd_we = 1'b1; rd_val = exec_pc_q + 32'd4;
                redirect = 1'b1; target = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin redirect = br_ok & taken; target = exec_pc_q + imm_b; end
            OP_LOAD:   if (f3 == 3'b010) begin ld = 1'b1; rd_we = 1'b1; rd_val = mem_data_i; end
            OP_STORE:  st = (f3 == 3'b010);
            OP_IMM, OP_REG: begin rd_we = alu_ok; rd_val = alu_res; end
            default: begin
`ifdef AYATSUKI_HALT_EN
                halt_set = (inst_i == 32'h0000_0073) || (inst_i == 32'h0010_0073);
`endif
            end
        endcase
        if (!exec_ok) begin
            rd_we    = 1'b0;
            redirect = 1'b0;
            ld       = 1'b0;
            st       = 1'b0;
`ifdef AYATSUKI_HALT_EN
            halt_set = 1'b0;
`endif
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (rd_we && rd != 5'd0)
            regs_d[rd] = rd_val;
        live_d = 1'b1;
        // exec_pc tracks the address of the instruction that will be on inst_i next cycle
        if (freeze) begin
            pc_d = pc_q; exec_pc_d = exec_pc_q; squash_d = squash_q;
        end else if (redirect) begin
            pc_d = target; exec_pc_d = pc_q; squash_d = 1'b1;
        end else begin
            pc_d = pc_q + 32'd4; exec_pc_d = pc_q; squash_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            exec_pc_q <= RESET_PC - 32'd4;
            squash_q  <= 1'b0;
            live_q    <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
`ifdef AYATSUKI_HALT_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            exec_pc_q <= exec_pc_d;
            squash_q  <= squash_d;
            live_q    <= live_d;
            regs_q    <= regs_d;
`ifdef AYATSUKI_HALT_EN
            halt_q    <= halt_d;
`endif
        end
    end

    assign inst_addr_o    = pc_q;
    assign mem_w_enable_o = st;
    assign mem_r_enable_o = ld;
    assign mem_enable_o   = st | ld;
    assign mem_w_addr_o   = st ? mem_addr : '0;
    assign mem_r_addr_o   = ld ? mem_addr : '0;
    assign mem_data_o     = st ? rs2_val : '0;
endmodule

// File: tb/tb_ayatsuki_core.sv
// Bench for ayatsuki_core: instruction-level reference model predicts per-cycle bus activity and final RAM.
module tb_ayatsuki_core;
`ifdef AYATSUKI_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam logic [31:0] OPI = 32'h13, OPR = 32'h33, LDO = 32'h03, STO = 32'h23;
    localparam int K_RST = 0, K_RUN = 1, K_BUB = 2, K_HLT = 3;

    bit          clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i, inst_addr_o, mem_w_addr_o, mem_r_addr_o, mem_data_i, mem_data_o;
    logic        mem_w_enable_o, mem_r_enable_o, mem_enable_o;

    logic [31:0] rom [64];
    logic [31:0] ram [64];
    logic [31:0] ram_init [64];
    logic [31:0] mram [64];
    logic [31:0] exp_addr [64], exp_waddr [64], exp_raddr [64], exp_wdata [64];
    logic        exp_we [64], exp_re [64];
    logic [31:0] act_addr [64], act_waddr [64], act_raddr [64], act_wdata [64];
    logic        act_we [64], act_re [64];
    int checks = 0, errors = 0;

    ayatsuki_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_o(inst_addr_o),
        .mem_w_enable_o(mem_w_enable_o), .mem_r_enable_o(mem_r_enable_o), .mem_enable_o(mem_enable_o),
        .mem_w_addr_o(mem_w_addr_o), .mem_r_addr_o(mem_r_addr_o), .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) inst_i <= 32'h0;
        else        inst_i <= rom[inst_addr_o[7:2]];

    always @(posedge clk)
        if (!rst_n) ram <= ram_init;
        else if (mem_w_enable_o) ram[mem_w_addr_o[7:2]] <= mem_data_o;

    assign mem_data_i = ram[mem_r_addr_o[7:2]];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin rom[i] = 32'h0; ram_init[i] = 32'h0; end
    endtask

    // Instruction-set reference: one slot per cycle, one bubble after each taken redirect.
    task automatic model_run(input int ncyc);
        logic [31:0] r [32];
        logic [31:0] cur, nxt, pend, w, a, b, y, res, ea, tgt, ii, si, bi, ji;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  sh;
        logic        wr, redir, halt, lt, ltu;
        int kind, nkind;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        for (int i = 0; i < 64; i++) mram[i] = ram_init[i];
        kind = K_RST; cur = 32'h0; pend = 32'h0; nxt = 32'h0; nkind = K_RUN;
        for (int c = 0; c < ncyc; c++) begin
            exp_we[c] = 1'b0; exp_re[c] = 1'b0;
            exp_waddr[c] = 32'h0; exp_raddr[c] = 32'h0; exp_wdata[c] = 32'h0;
            if (kind == K_RST) begin nkind = K_RUN; nxt = 32'h0; end
            else if (kind == K_BUB) begin nkind = K_RUN; nxt = pend; end
            else if (kind == K_HLT) begin nkind = K_HLT; nxt = cur; end
            else begin
                w = rom[cur[7:2]];
                op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
                a = r[w[19:15]]; b = r[w[24:20]];
                ii = {{20{w[31]}}, w[31:20]};
                si = {{20{w[31]}}, w[31:25], w[11:7]};
                bi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                ji = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                wr = 1'b0; redir = 1'b0; halt = 1'b0; res = 32'h0; tgt = 32'h0;
                if (op == 7'h37) begin wr = 1'b1; res = {w[31:12], 12'h0}; end
                else if (op == 7'h17) begin wr = 1'b1; res = cur + {w[31:12], 12'h0}; end
                else if (op == 7'h6f) begin wr = 1'b1; res = cur + 4; redir = 1'b1; tgt = cur + ji; end
                else if (op == 7'h67 && f3 == 3'd0) begin
                    wr = 1'b1; res = cur + 4; redir = 1'b1; tgt = a + ii; tgt[0] = 1'b0;
                end else if (op == 7'h63) begin
                    lt = $signed(a) < $signed(b); ltu = a < b;
                    if (f3 == 0) redir = (a == b);
                    else if (f3 == 1) redir = (a != b);
                    else if (f3 == 4) redir = lt;
                    else if (f3 == 5) redir = !lt;
                    else if (f3 == 6) redir = ltu;
                    else if (f3 == 7) redir = !ltu;
                    tgt = cur + bi;
                end else if (op == 7'h03 && f3 == 3'd2) begin
                    ea = a + ii; wr = 1'b1; res = mram[ea[7:2]];
                    exp_re[c] = 1'b1; exp_raddr[c] = ea;
                end else if (op == 7'h23 && f3 == 3'd2) begin
                    ea = a + si; mram[ea[7:2]] = b;
                    exp_we[c] = 1'b1; exp_waddr[c] = ea; exp_wdata[c] = b;
                end else if (op == 7'h13 || op == 7'h33) begin
                    y = (op == 7'h33) ? b : ii;
                    sh = y[4:0];
                    wr = 1'b1;
                    case (f3)
                        3'd0: res = (op == 7'h33 && f7 == 7'h20) ? a - y : a + y;
                        3'd1: res = a << sh;
                        3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < y) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ y;
                        3'd5: res = (a >> sh) | ((f7 == 7'h20 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                        3'd6: res = a | y;
                        default: res = a & y;
                    endcase
                    if (op == 7'h33 && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) wr = 1'b0;
                    if (op == 7'h13 && f3 == 1 && f7 != 0) wr = 1'b0;
                    if (op == 7'h13 && f3 == 5 && f7 != 0 && f7 != 7'h20) wr = 1'b0;
                end else if (HALT_EN && (w == 32'h73 || w == 32'h0010_0073)) halt = 1'b1;
                if (wr && w[11:7] != 0) r[w[11:7]] = res;
                nxt = cur + 4;
                if (halt) nkind = K_HLT;
                else if (redir) begin nkind = K_BUB; pend = tgt; end
                else nkind = K_RUN;
            end
            exp_addr[c] = nxt;
            kind = nkind; cur = nxt;
        end
    endtask

    task automatic run_test(input string name, input int ncyc);
        model_run(ncyc);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({name, " rst addr"}, inst_addr_o, 32'h0);
        chk({name, " rst en"}, {29'h0, mem_enable_o, mem_w_enable_o, mem_r_enable_o}, 32'h0);
        chk({name, " rst waddr"}, mem_w_addr_o, 32'h0);
        chk({name, " rst raddr"}, mem_r_addr_o, 32'h0);
        chk({name, " rst wdata"}, mem_data_o, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            act_addr[c] = inst_addr_o; act_we[c] = mem_w_enable_o; act_re[c] = mem_r_enable_o;
            act_waddr[c] = mem_w_addr_o; act_raddr[c] = mem_r_addr_o; act_wdata[c] = mem_data_o;
            chk($sformatf("%s c%0d addr", name, c), inst_addr_o, exp_addr[c]);
            chk($sformatf("%s c%0d en w/r/any", name, c), {29'h0, mem_w_enable_o, mem_r_enable_o, mem_enable_o},
                {29'h0, exp_we[c], exp_re[c], exp_we[c] | exp_re[c]});
            chk($sformatf("%s c%0d waddr", name, c), mem_w_addr_o, exp_waddr[c]);
            chk($sformatf("%s c%0d raddr", name, c), mem_r_addr_o, exp_raddr[c]);
            chk($sformatf("%s c%0d wdata", name, c), mem_data_o, exp_wdata[c]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) chk($sformatf("%s ram[%0d]", name, i), ram[i], mram[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_prog();

        rom[0] = enc_i(32'h12, 0, 0, 1, OPI);
        rom[1] = enc_s(0, 1, 0);
        run_test("store_imm", 6);
        chk("store_imm we@c2", {31'h0, act_we[2]}, 32'h1);
        chk("store_imm wdata@c2", act_wdata[2], 32'h12);
        chk("store_imm waddr@c2", act_waddr[2], 32'h0);
        chk("store_imm word0", ram[0], 32'h0000_0012);

        clear_prog();
        rom[0] = enc_u(32'h12345, 2, 32'h37);
        rom[1] = enc_i(32'h678, 2, 0, 2, OPI);
        rom[2] = enc_r(32'h20, 0, 2, 0, 3);
        rom[3] = enc_s(0, 3, 0);
        run_test("lui_sub", 8);
        chk("lui_sub word0", ram[0], 32'h1234_5678);

        clear_prog();
        ram_init[2] = 32'hDEAD_BEEF;
        rom[0] = enc_i(8, 0, 2, 4, LDO);
        rom[1] = enc_i(1, 4, 0, 4, OPI);
        rom[2] = enc_s(0, 4, 0);
        run_test("load_use", 7);
        chk("load_use raddr@c1", act_raddr[1], 32'h8);
        chk("load_use word0", ram[0], 32'hDEAD_BEF0);

        clear_prog();
        rom[0] = enc_i(1, 0, 0, 1, OPI);
        rom[1] = enc_b(8, 1, 1, 0);
        rom[2] = enc_i(7, 0, 0, 5, OPI);
        rom[3] = enc_s(0, 5, 0);
        run_test("br_squash", 8);
        chk("br_squash word0", ram[0], 32'h0);
        chk("br_squash addr c2", act_addr[2], 32'h8);
        chk("br_squash addr c3", act_addr[3], 32'hC);
        chk("br_squash addr c4", act_addr[4], 32'h10);

        clear_prog();
        rom[4] = enc_j(8, 1);
        rom[5] = enc_i(32'h55, 0, 0, 1, OPI);
        rom[6] = enc_s(0, 1, 0);
        run_test("jal_link", 10);
        chk("jal_link word0", ram[0], 32'h14);

        clear_prog();
        rom[0]  = enc_i(-5, 0, 0, 1, OPI);
        rom[1]  = enc_i(3, 0, 0, 2, OPI);
        rom[2]  = enc_r(32'h20, 2, 1, 5, 3);
        rom[3]  = enc_r(0, 2, 1, 5, 4);
        rom[4]  = enc_r(0, 2, 1, 2, 5);
        rom[5]  = enc_r(0, 2, 1, 3, 6);
        rom[6]  = enc_s(0, 3, 0);
        rom[7]  = enc_s(4, 4, 0);
        rom[8]  = enc_s(8, 5, 0);
        rom[9]  = enc_s(12, 6, 0);
        rom[10] = enc_i(32'hF0, 1, 4, 7, OPI);
        rom[11] = enc_i(4, 2, 1, 8, OPI);
        rom[12] = enc_u(1, 9, 32'h17);
        rom[13] = enc_s(16, 7, 0);
        rom[14] = enc_s(20, 8, 0);
        rom[15] = enc_s(24, 9, 0);
        rom[16] = enc_i(32'h0F, 1, 7, 10, OPI);
        rom[17] = enc_s(28, 10, 0);
        ram_init[3] = 32'h5555_5555;
        run_test("alu_mix", 22);
        chk("alu_mix sra", ram[0], 32'hFFFF_FFFF);
        chk("alu_mix srl", ram[1], 32'h1FFF_FFFF);
        chk("alu_mix slt", ram[2], 32'h1);
        chk("alu_mix sltu", ram[3], 32'h0);
        chk("alu_mix xori", ram[4], 32'hFFFF_FF0B);
        chk("alu_mix slli", ram[5], 32'h30);
        chk("alu_mix auipc", ram[6], 32'h1030);
        chk("alu_mix andi", ram[7], 32'hB);

        clear_prog();
        rom[0]  = enc_i(-1, 0, 0, 1, OPI);
        rom[1]  = enc_i(1, 0, 0, 2, OPI);
        rom[2]  = enc_b(8, 2, 1, 4);
        rom[3]  = enc_i(1, 0, 0, 10, OPI);
        rom[4]  = enc_b(8, 2, 1, 6);
        rom[5]  = enc_i(2, 0, 0, 11, OPI);
        rom[6]  = enc_b(8, 2, 1, 5);
        rom[7]  = enc_i(41, 0, 0, 12, 32'h67);
        rom[8]  = enc_i(9, 0, 0, 13, OPI);
        rom[9]  = enc_i(10, 0, 0, 13, OPI);
        rom[10] = enc_s(0, 10, 0);
        rom[11] = enc_s(4, 11, 0);
        rom[12] = enc_s(8, 12, 0);
        rom[13] = enc_s(12, 13, 0);
        ram_init[3] = 32'h0000_AAAA;
        run_test("br_jalr", 18);
        chk("br_jalr blt skip", ram[0], 32'h0);
        chk("br_jalr bltu fall", ram[1], 32'h2);
        chk("br_jalr link", ram[2], 32'h20);
        chk("br_jalr squash", ram[3], 32'h0);

        clear_prog();
        ram_init[0] = 32'h77;
        rom[0] = enc_i(5, 0, 0, 1, OPI);
        rom[1] = enc_i(0, 0, 0, 1, LDO);
        rom[2] = 32'h0000_0073;
        rom[3] = enc_s(4, 1, 0);
        run_test("ecall", 9);
        chk("ecall word1", ram[1], HALT_EN ? 32'h0 : 32'h5);
        chk("ecall addr c5", act_addr[5], HALT_EN ? 32'hC : 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
